// File: rtl/multicycle_control_hs_if.sv
// Control-to-core bundle for the multicycle controller: opcode/stall/memory-ready in,
// datapath state, memory strobes and status out.
interface multicycle_control_hs_if #(
    parameter int OPCODE_W = 6,
    parameter int CNT_W    = 32
);
    logic [OPCODE_W-1:0] opcode;
    logic                stall;
    logic                mem_ready;
    logic [3:0]          state;
    logic                mem_req;
    logic                mem_we;
    logic                instr_done;
    logic [CNT_W-1:0]    retired;
    logic                halted;
    logic [1:0]          err_code;

    // master: the controller; slave: opcode source / memory side.
    modport master (
        input  opcode, stall, mem_ready,
        output state, mem_req, mem_we, instr_done, retired, halted, err_code
    );
    modport slave (
        output opcode, stall, mem_ready,
        input  state, mem_req, mem_we, instr_done, retired, halted, err_code
    );
endinterface

// File: rtl/multicycle_control_hs.sv
// Multicycle CPU control FSM with memory ready handshake + timeout, global stall,
// sticky HALT/ERROR, retired-instruction counter and instruction-done pulse.
module multicycle_control_hs #(
    parameter int OPCODE_W    = 6,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    multicycle_control_hs_if.master  bus
);
    localparam int WW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] TO_LAST = WW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    typedef enum logic [3:0] {
        S_IF      = 4'd0,  S_RF     = 4'd1,  S_IMM2  = 4'd2,  S_ALU_R3 = 4'd3,
        S_ALU_RI3 = 4'd4,  S_ALU4   = 4'd5,  S_BR3   = 4'd6,  S_MEM3   = 4'd7,
        S_LOAD4   = 4'd8,  S_STORE4 = 4'd9,  S_LOAD5 = 4'd10, S_J3     = 4'd11,
        S_HALT    = 4'd12, S_ERROR  = 4'd13
    } state_t;

    state_t           state_q, state_d;
    logic [WW-1:0]    wcnt_q, wcnt_d;
    logic [1:0]       err_q, err_d;
    logic [CNT_W-1:0] retired_q;
    logic             done_q;
    logic             retire;

    logic [2:0] h;
    logic       m, is_halt, is_ldi, mem_st;

    always_comb begin
        h       = bus.opcode[OPCODE_W-1 -: 3];
        m       = bus.opcode[OPCODE_W-4];
        is_halt = &bus.opcode;
        is_ldi  = (h == 3'b111) && (bus.opcode[OPCODE_W-4:0] == '0);
        mem_st  = (state_q == S_IF) || (state_q == S_LOAD4) || (state_q == S_STORE4);
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        retire  = 1'b0;
        if (mem_st && !bus.mem_ready) begin
            if (MEM_TIMEOUT != 0 && wcnt_q == TO_LAST) begin
                state_d = S_ERROR;
                err_d   = 2'b10;
            end else begin
                wcnt_d = wcnt_q + 1'b1;
            end
        end else begin
            case (state_q)
                S_IF: begin
                    if (is_halt)     state_d = S_HALT;
                    else if (is_ldi) state_d = S_IMM2;
                    else             state_d = S_RF;
                end
                S_RF: begin
                    case (h)
                        3'b000, 3'b001: state_d = S_ALU_R3;
                        3'b010, 3'b011: state_d = S_ALU_RI3;
                        3'b100:         state_d = S_BR3;
                        3'b101:         state_d = S_MEM3;
                        3'b110:         state_d = S_J3;
                        default: begin
                            state_d = S_ERROR;
                            err_d   = 2'b01;
                        end
                    endcase
                end
                S_ALU_R3, S_ALU_RI3: state_d = S_ALU4;
                S_MEM3:              state_d = m ? S_STORE4 : S_LOAD4;
                S_LOAD4:             state_d = S_LOAD5;
                S_IMM2, S_ALU4, S_BR3, S_STORE4, S_LOAD5, S_J3: begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end
                S_HALT, S_ERROR:     state_d = state_q;
                // Codes 14/15 can only appear through an upset; treat as illegal.
                default: begin
                    state_d = S_ERROR;
                    err_d   = 2'b01;
                end
            endcase
        end
        if (state_d != state_q) wcnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            wcnt_q    <= '0;
            err_q     <= 2'b00;
            retired_q <= '0;
            done_q    <= 1'b0;
        end else if (bus.stall) begin
            done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
            done_q  <= retire;
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    assign bus.state      = state_q;
    assign bus.mem_req    = mem_st;
    assign bus.mem_we     = (state_q == S_STORE4);
    assign bus.halted     = (state_q == S_HALT);
    assign bus.instr_done = done_q & ~bus.stall;
    assign bus.retired    = retired_q;
    assign bus.err_code   = err_q;
endmodule

// File: tb/tb_multicycle_control_hs.sv
// Bench for multicycle_control_hs: directed per-cycle vector tables, then random
// stimulus against a path-table reference model.
module tb_multicycle_control_hs;
    localparam int OW = 6, CW = 4, TO = 4;
    localparam logic [5:0] ALU = 6'b000010, LD = 6'b101000, STR = 6'b101100,
                           ILL = 6'b111010, HLT = 6'b111111, JMP = 6'b110000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_hs_if #(.OPCODE_W(OW), .CNT_W(CW)) bus ();
    multicycle_control_hs #(.OPCODE_W(OW), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int n_chk = 0, n_pass = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_outs(input string tag, input int st, input int done, input int ret, input int err);
        check({tag, " state"},      int'(bus.state), st);
        check({tag, " mem_req"},    int'(bus.mem_req), int'(st == 0 || st == 8 || st == 9));
        check({tag, " mem_we"},     int'(bus.mem_we), int'(st == 9));
        check({tag, " halted"},     int'(bus.halted), int'(st == 12));
        check({tag, " instr_done"}, int'(bus.instr_done), done);
        check({tag, " retired"},    int'(bus.retired), ret);
        check({tag, " err_code"},   int'(bus.err_code), err);
    endtask

    typedef struct {
        logic       rst_n;
        logic [5:0] op;
        logic       stall;
        logic       rdy;
        int         st;
        int         done;
        int         ret;
        int         err;
    } vec_t;
    vec_t vecs[$];

    function automatic void add(input logic r, input logic [5:0] op, input logic s, input logic rd,
                                input int st, input int done = 0, input int ret = 0, input int err = 0);
        vec_t v;
        v.rst_n = r; v.op = op; v.stall = s; v.rdy = rd;
        v.st = st; v.done = done; v.ret = ret; v.err = err;
        vecs.push_back(v);
    endfunction

    // ---- reference model: each opcode expands to its list of visited states ----
    int m_path[5];
    int m_len, m_idx, m_wait, m_ret, m_err, m_term, m_done;

    function automatic void build(input logic [5:0] op);
        logic [5:0] o;
        o = op;
        m_path = '{0, 0, 0, 0, 0};
        if (o == 6'h3f)            begin m_path[1] = 12; m_len = 2; end
        else if (o == 6'b111000)   begin m_path[1] = 2;  m_len = 2; end
        else begin
            m_path[1] = 1;
            case (o[5:3])
                3'd0, 3'd1: begin m_path[2] = 3; m_path[3] = 5; m_len = 4; end
                3'd2, 3'd3: begin m_path[2] = 4; m_path[3] = 5; m_len = 4; end
                3'd4:       begin m_path[2] = 6; m_len = 3; end
                3'd5: begin
                    m_path[2] = 7;
                    if (o[2]) begin m_path[3] = 9; m_len = 4; end
                    else begin m_path[3] = 8; m_path[4] = 10; m_len = 5; end
                end
                3'd6:       begin m_path[2] = 11; m_len = 3; end
                default:    begin m_path[2] = 13; m_len = 3; end
            endcase
        end
    endfunction

    function automatic int m_state();
        return (m_term != 0) ? m_term : m_path[m_idx];
    endfunction

    function automatic void m_reset();
        m_idx = 0; m_wait = 0; m_ret = 0; m_err = 0; m_term = 0; m_done = 0;
        m_path = '{0, 0, 0, 0, 0}; m_len = 1;
    endfunction

    function automatic void m_step(input logic [5:0] op, input logic stall, input logic rdy);
        int cur;
        cur = m_state();
        m_done = 0;
        if (stall || m_term != 0) return;
        if ((cur == 0 || cur == 8 || cur == 9) && !rdy) begin
            if (m_wait == TO - 1) begin m_term = 13; m_err = 2; end
            else m_wait++;
        end else begin
            m_wait = 0;
            if (m_idx == 0) build(op);
            if (m_idx + 1 < m_len) begin
                m_idx++;
                if (m_path[m_idx] == 12) m_term = 12;
                if (m_path[m_idx] == 13) begin m_term = 13; m_err = 1; end
            end else begin
                m_idx = 0;
                m_ret = (m_ret + 1) % (1 << CW);
                m_done = 1;
            end
        end
    endfunction

    initial begin
        int term_cnt;
        logic [5:0] op;
        logic st, rd;
        rst_n = 1'b0;
        bus.opcode = '0; bus.stall = 1'b0; bus.mem_ready = 1'b0;

        // ALU_R: 0,1,3,5,0 with one done pulse
        add(0, ALU, 0, 1, 0);
        add(1, ALU, 0, 1, 0); add(1, ALU, 0, 1, 1); add(1, ALU, 0, 1, 3); add(1, ALU, 0, 1, 5);
        add(1, ALU, 0, 0, 0, 1, 1); add(1, ALU, 0, 0, 0, 0, 1);
        // LD with 3 wait cycles in LOAD4 (ready on the last allowed edge), then IF timeout
        add(0, LD, 0, 1, 0);
        add(1, LD, 0, 1, 0); add(1, LD, 0, 1, 1); add(1, LD, 0, 1, 7);
        add(1, LD, 0, 0, 8); add(1, LD, 0, 0, 8); add(1, LD, 0, 0, 8); add(1, LD, 0, 1, 8);
        add(1, LD, 0, 1, 10);
        add(1, LD, 0, 0, 0, 1, 1); add(1, LD, 0, 0, 0, 0, 1); add(1, LD, 0, 0, 0, 0, 1); add(1, LD, 0, 0, 0, 0, 1);
        add(1, LD, 0, 1, 13, 0, 1, 2); add(1, LD, 0, 1, 13, 0, 1, 2); add(1, ALU, 0, 1, 13, 0, 1, 2);
        // illegal opcode, then HALT
        add(0, ILL, 0, 1, 0);
        add(1, ILL, 0, 1, 0); add(1, ILL, 0, 1, 1); add(1, ILL, 0, 1, 13, 0, 0, 1); add(1, ALU, 0, 1, 13, 0, 0, 1);
        add(0, HLT, 0, 1, 0);
        add(1, HLT, 0, 1, 0); add(1, HLT, 0, 1, 12); add(1, ALU, 0, 1, 12); add(1, ALU, 0, 1, 12);
        // STORE4 stall with ready pulsed; wait count must survive the stall
        add(0, STR, 0, 1, 0);
        add(1, STR, 0, 1, 0); add(1, STR, 0, 1, 1); add(1, STR, 0, 1, 7); add(1, STR, 0, 0, 9);
        add(1, STR, 1, 0, 9); add(1, STR, 1, 1, 9); add(1, STR, 1, 1, 9); add(1, STR, 1, 0, 9); add(1, STR, 1, 0, 9);
        add(1, STR, 0, 0, 9); add(1, STR, 0, 0, 9); add(1, STR, 0, 1, 9);
        add(1, STR, 1, 0, 0, 0, 1); add(1, STR, 0, 0, 0, 0, 1);
        // 17 jumps wrap the 4-bit counter to 1, then reset mid-J3
        add(0, JMP, 0, 1, 0);
        for (int i = 0; i < 17; i++) begin
            add(1, JMP, 0, 1, 0, int'(i > 0), i % 16);
            add(1, JMP, 0, 1, 1, 0, i % 16);
            add(1, JMP, 0, 1, 11, 0, i % 16);
        end
        add(1, JMP, 0, 1, 0, 1, 1); add(1, JMP, 0, 1, 1, 0, 1);
        add(0, JMP, 0, 1, 0, 0, 0);
        add(1, JMP, 0, 1, 0, 0, 0); add(1, JMP, 0, 1, 1, 0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst_n = vecs[i].rst_n; bus.opcode = vecs[i].op;
            bus.stall = vecs[i].stall; bus.mem_ready = vecs[i].rdy;
            #1;
            check_outs($sformatf("vec%0d", i), vecs[i].st, vecs[i].done, vecs[i].ret, vecs[i].err);
        end

        // ---- random phase ----
        @(negedge clk);
        rst_n = 1'b0;
        m_reset();
        term_cnt = 0;
        op = ALU;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            rst_n = !((m_term != 0 && term_cnt > 3) || ($urandom_range(0, 299) == 0));
            if (m_term == 0 && m_idx == 0) begin
                case ($urandom_range(0, 11))
                    0:  op = {3'b000, 3'($urandom)};
                    1:  op = {3'b001, 3'($urandom)};
                    2:  op = {2'b01, 4'($urandom)};
                    3:  op = {3'b100, 3'($urandom)};
                    4, 5: op = {3'b101, 3'($urandom)};
                    6:  op = {3'b110, 3'($urandom)};
                    7:  op = 6'b111000;
                    8:  op = 6'b111111;
                    default: op = 6'($urandom);
                endcase
            end
            st = ($urandom_range(0, 6) == 0);
            rd = ($urandom_range(0, 4) < 3);
            bus.opcode = op; bus.stall = st; bus.mem_ready = rd;
            #1;
            if (!rst_n) begin m_reset(); term_cnt = 0; end
            check_outs($sformatf("rnd%0d", cyc), m_state(), int'(m_done != 0 && !st), m_ret, m_err);
            if (rst_n) begin
                m_step(op, st, rd);
                term_cnt = (m_term != 0) ? term_cnt + 1 : 0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/multicycle_control_hs.md
Name: multicycle_control_hs

Overview:
- Parametrised successor to the multicycle CPU control FSM; drives the datapath state for every instruction class.
- Adds three things the previous controller lacks:
  - an asynchronous active-low reset;
  - a memory request/ready handshake with a configurable timeout;
  - a global stall input, sticky HALT and ERROR states, a retired-instruction counter and an instruction-done pulse.
- Sits between the instruction register/opcode source and the datapath/memory interface of the multicycle core.

Parameters:
- OPCODE_W, 6: opcode width. Must be >= 6. Fields are taken from the MSBs.
- MEM_TIMEOUT, 15: consecutive not-ready cycles tolerated in a memory state. 0 disables the timeout.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  OPCODE_W  current instruction opcode.
- stall  in  1  global hold; freezes all registers when high.
- mem_ready  in  1  memory completion for the current request.
- state  out  4  current control state (encoding below).
- mem_req  out  1  memory request; high in IF, LOAD4, STORE4.
- mem_we  out  1  memory write; high only in STORE4.
- instr_done  out  1  registered one-cycle pulse per completed instruction.
- retired  out  CNT_W  count of completed instructions.
- halted  out  1  high while in HALT.
- err_code  out  2  00 none, 01 illegal opcode, 10 memory timeout. Sticky.

Behaviour:
- Opcode fields, with H = opcode[OPCODE_W-1 -: 3] and M = opcode[OPCODE_W-4]:
  - H=00x: ALU_R.
  - H=01x: ALU_RI.
  - H=100: BRANCH.
  - H=101: MEM_REF, with M=0 LD and M=1 STR.
  - H=110: JUMP.
  - LDI = {3'b111, zeros}.
  - HALT = all ones.
  - Any other H=111 value is illegal.
- State encoding:
  - IF=0, RF=1, IMM2=2, ALU_R3=3, ALU_RI3=4, ALU4=5, BR3=6, MEM3=7.
  - LOAD4=8, STORE4=9, LOAD5=10, J3=11, HALT=12, ERROR=13.
  - Codes 14 and 15 are unreachable. If either is ever held, go to ERROR with err_code 01.
- Reset (rst_n low, asynchronous): state=IF, wait counter=0, retired=0, instr_done=0, err_code=00. mem_req=1 (because state is IF), mem_we=0, halted=0. Reset asserted mid-instruction aborts it immediately; no instr_done pulse is produced.
- Stall (stall=1): no register changes. This covers state, wait counter, retired, err_code and instr_done; instr_done is forced to 0 during stall. mem_ready is ignored while stalled, so memory must hold ready until it is accepted. Outputs derived from state stay asserted.
- Memory states (IF, LOAD4, STORE4), evaluated at each unstalled edge:
  - mem_ready=1: advance to the next state, wait counter cleared.
  - mem_ready=0 and MEM_TIMEOUT!=0 and wait counter==MEM_TIMEOUT-1: go to ERROR, err_code=10.
  - Otherwise: stay in the state, wait counter +1.
  - The wait counter is ceil(log2(MEM_TIMEOUT+1)) bits wide and is cleared on entering any state.
- Transitions (non-memory states advance every unstalled cycle):
  - IF (on ready): HALT opcode → HALT; LDI → IMM2; otherwise → RF. The opcode is sampled at the accepting edge.
  - RF: ALU_R → ALU_R3; ALU_RI → ALU_RI3; BRANCH → BR3; MEM_REF → MEM3; JUMP → J3; illegal → ERROR with err_code=01.
  - ALU_R3 and ALU_RI3 → ALU4. MEM3: M=0 → LOAD4, M=1 → STORE4. LOAD4 (on ready) → LOAD5.
  - Completion states: IMM2, ALU4, BR3, STORE4 (on ready), LOAD5, J3. Each goes to IF.
  - HALT and ERROR are absorbing until reset. Outputs there: mem_req=0, mem_we=0, halted=1 in HALT only.
- Completion: on each edge that leaves a completion state for IF, retired <= retired+1 (wrapping modulo 2^CNT_W) and instr_done <= 1. On all other edges instr_done <= 0. instr_done is therefore high for exactly the first cycle back in IF.
- Latency with zero-wait memory (cycles per instruction, IF through the last state inclusive): LDI 2, ALU 4, BRANCH 3, JUMP 3, STORE 4, LOAD 5. Each memory state adds one cycle per not-ready cycle.

Test Plan:
- Reset, then ALU_R opcode 6'b000010 with mem_ready tied 1 → state sequence 0,1,3,5,0. instr_done high for one cycle on the return to 0. retired=1.
- LD opcode 6'b101000 with mem_ready low for 3 cycles in LOAD4 → sequence 0,1,7,8,8,8,8,10,0. mem_we never 1. retired increments by 1.
- MEM_TIMEOUT=4, ready held 0 in IF → ERROR (13) after exactly 4 cycles, err_code=10, mem_req=0. Stays in ERROR until rst_n=0.
- Opcode 6'b111010 (illegal) → 0,1,13 with err_code=01. HALT opcode 6'b111111 → 0,12 with halted=1, retired unchanged, sticky.
- stall=1 for 5 cycles while in STORE4, with mem_ready pulsed during the stall → state, wait counter and retired unchanged. After stall drops, ready=1 → IF with mem_we=1 in the final STORE4 cycle.
- CNT_W=4: run 17 JUMP instructions (6'b110000) → retired wraps to 1. Then assert rst_n low mid-J3 → immediately state=0, retired=0, instr_done=0.
